// File: rtl/shift_exec_pipe_if.sv
// Request/result channel bundle for shift_exec_pipe.
// Both directions use valid/ready: a transfer happens on a rising edge where valid && ready.
interface shift_exec_pipe_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_dir;
  logic [4:0]  in_amt;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_carry;
  logic        out_zero;

  modport master (
    output in_valid, in_dir, in_amt, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_carry, out_zero
  );

  modport slave (
    input  in_valid, in_dir, in_amt, in_data, out_ready,
    output in_ready, out_valid, out_data, out_carry, out_zero
  );
endinterface

// File: rtl/shift_exec_pipe.sv
// Two-stage 32-bit shifter: stage A holds the operand, stage B holds the registered
// result and flags. SLL / SRA with last-bit-out carry and a zero flag.
module shift_exec_pipe #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  shift_exec_pipe_if.slave bus,
  output logic [CNT_W-1:0] op_cnt
);

  // Handshake: in/out transfers occur on a rising edge where valid && ready.
  // Valid never depends on ready; in_ready may depend combinationally on out_ready.

  logic        a_valid_q, a_valid_d;
  logic        a_dir_q,   a_dir_d;
  logic [4:0]  a_amt_q,   a_amt_d;
  logic [31:0] a_data_q,  a_data_d;

  logic        b_valid_q, b_valid_d;
  logic [31:0] b_data_q,  b_data_d;
  logic        b_carry_q, b_carry_d;
  logic        b_zero_q,  b_zero_d;

  logic [CNT_W-1:0] op_cnt_q, op_cnt_d;

  logic        advance;
  logic        in_xfer;
  logic        out_xfer;
  logic [31:0] sh_data;
  logic        sh_carry;
  logic [5:0]  l_idx;
  logic [4:0]  r_idx;

  always_comb begin
    advance  = a_valid_q && (!b_valid_q || bus.out_ready);
    in_xfer  = bus.in_valid && (!a_valid_q || advance);
    out_xfer = b_valid_q && bus.out_ready;
  end

  // Shift datapath works straight off stage A; only the result is registered.
  always_comb begin
    l_idx = 6'd32 - {1'b0, a_amt_q};
    r_idx = a_amt_q - 5'd1;
    if (a_dir_q) begin
      sh_data  = 32'($signed(a_data_q) >>> a_amt_q);
      sh_carry = a_data_q[r_idx];
    end else begin
      sh_data  = a_data_q << a_amt_q;
      sh_carry = a_data_q[l_idx[4:0]];
    end
    if (a_amt_q == 5'd0) begin
      sh_carry = 1'b0;
    end
  end

  always_comb begin
    a_valid_d = a_valid_q;
    a_dir_d   = a_dir_q;
    a_amt_d   = a_amt_q;
    a_data_d  = a_data_q;
    if (in_xfer) begin
      a_valid_d = 1'b1;
      a_dir_d   = bus.in_dir;
      a_amt_d   = bus.in_amt;
      a_data_d  = bus.in_data;
    end else if (advance) begin
      a_valid_d = 1'b0;
    end

    b_valid_d = b_valid_q;
    b_data_d  = b_data_q;
    b_carry_d = b_carry_q;
    b_zero_d  = b_zero_q;
    if (advance) begin
      b_valid_d = 1'b1;
      b_data_d  = sh_data;
      b_carry_d = sh_carry;
      b_zero_d  = (sh_data == 32'd0);
    end else if (out_xfer) begin
      b_valid_d = 1'b0;
    end

    op_cnt_d = op_cnt_q;
    if (out_xfer) begin
      op_cnt_d = op_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid_q <= 1'b0;
      a_dir_q   <= 1'b0;
      a_amt_q   <= 5'd0;
      a_data_q  <= 32'd0;
      b_valid_q <= 1'b0;
      b_data_q  <= 32'd0;
      b_carry_q <= 1'b0;
      b_zero_q  <= 1'b0;
      op_cnt_q  <= '0;
    end else begin
      a_valid_q <= a_valid_d;
      a_dir_q   <= a_dir_d;
      a_amt_q   <= a_amt_d;
      a_data_q  <= a_data_d;
      b_valid_q <= b_valid_d;
      b_data_q  <= b_data_d;
      b_carry_q <= b_carry_d;
      b_zero_q  <= b_zero_d;
      op_cnt_q  <= op_cnt_d;
    end
  end

  assign bus.in_ready  = !a_valid_q || advance;
  assign bus.out_valid = b_valid_q;
  assign bus.out_data  = b_data_q;
  assign bus.out_carry = b_carry_q;
  assign bus.out_zero  = b_zero_q;
  assign op_cnt        = op_cnt_q;

endmodule

// File: tb/tb_shift_exec_pipe.sv
// Scoreboard bench for shift_exec_pipe: directed shifts, backpressure, streaming,
// mid-flight reset and counter wrap on a narrow-counter twin instance.
module tb_shift_exec_pipe;
  localparam int W = 34;

  logic        clk;
  logic        rst_n;
  logic [15:0] op_cnt;
  logic [3:0]  op_cnt_s;

  shift_exec_pipe_if if0 ();
  shift_exec_pipe_if if1 ();

  shift_exec_pipe #(.CNT_W(16)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (if0),
    .op_cnt (op_cnt)
  );

  // Twin with a 4-bit counter sees identical stimulus.
  shift_exec_pipe #(.CNT_W(4)) dut_s (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (if1),
    .op_cnt (op_cnt_s)
  );

  assign if1.in_valid  = if0.in_valid;
  assign if1.in_dir    = if0.in_dir;
  assign if1.in_amt    = if0.in_amt;
  assign if1.in_data   = if0.in_data;
  assign if1.out_ready = if0.out_ready;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [W-1:0] exp_q[$];
  int           stamp_q[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           exp_cnt = 0;
  logic         chk_lat = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: shift inside a 64-bit window; the bit adjacent to the result is the carry.
  function automatic logic [W-1:0] model(input logic d, input logic [4:0] a, input logic [31:0] x);
    logic [63:0] w;
    logic [31:0] r;
    logic        c;
    if (!d) begin
      w = {32'd0, x} << a;
      r = w[31:0];
      c = w[32];
    end else begin
      w = 64'($signed({x, 32'd0}) >>> a);
      r = w[63:32];
      c = w[31];
    end
    return {c, (r == 32'd0), r};
  endfunction

  // One cycle: called just after a falling edge, returns just after the next one.
  task automatic step(input logic v, input logic d, input logic [4:0] a, input logic [31:0] x,
                      input logic ordy, output logic acc);
    logic [W-1:0] e;
    int           s;
    if0.in_valid  = v;
    if0.in_dir    = d;
    if0.in_amt    = a;
    if0.in_data   = x;
    if0.out_ready = ordy;
    #1;
    acc = v && if0.in_ready;
    if (if0.out_valid && ordy) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        s = stamp_q.pop_front();
        chk("out_data", if0.out_data, e[31:0]);
        chk("out_zero", {31'd0, if0.out_zero}, {31'd0, e[32]});
        chk("out_carry", {31'd0, if0.out_carry}, {31'd0, e[33]});
        if (chk_lat) chk("latency", cyc - s, 32'd2);
        exp_cnt++;
      end
    end
    if (acc) begin
      exp_q.push_back(model(d, a, x));
      stamp_q.push_back(cyc);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input logic ordy);
    logic acc;
    step(1'b0, 1'b0, 5'd0, 32'd0, ordy, acc);
  endtask

  // Single request, then check the registered result with literal expectations.
  task automatic directed(input string tag, input logic d, input logic [4:0] a, input logic [31:0] x,
                          input logic [31:0] ed, input logic ec, input logic ez);
    logic acc;
    step(1'b1, d, a, x, 1'b1, acc);
    chk({tag, "_acc"}, {31'd0, acc}, 32'd1);
    idle(1'b1);
    chk({tag, "_valid"}, {31'd0, if0.out_valid}, 32'd1);
    chk({tag, "_data"}, if0.out_data, ed);
    chk({tag, "_carry"}, {31'd0, if0.out_carry}, {31'd0, ec});
    chk({tag, "_zero"}, {31'd0, if0.out_zero}, {31'd0, ez});
    idle(1'b1);
  endtask

  initial begin
    logic        acc;
    logic [31:0] base;
    logic        d;
    logic [4:0]  a;
    logic [31:0] x;
    int          n;

    rst_n         = 1'b0;
    if0.in_valid  = 1'b0;
    if0.in_dir    = 1'b0;
    if0.in_amt    = 5'd0;
    if0.in_data   = 32'd0;
    if0.out_ready = 1'b0;
    #3;
    chk("rst_out_valid", {31'd0, if0.out_valid}, 32'd0);
    chk("rst_out_data", if0.out_data, 32'd0);
    chk("rst_in_ready", {31'd0, if0.in_ready}, 32'd1);
    chk("rst_op_cnt", {16'd0, op_cnt}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // first edge after release accepts; left shift
    directed("sll4", 1'b0, 5'd4, 32'h8000_000F, 32'h0000_00F0, 1'b0, 1'b0);
    chk("sll4_cnt", {16'd0, op_cnt}, 32'd1);
    directed("sra31", 1'b1, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    directed("sra1", 1'b1, 5'd1, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1);
    directed("sll1", 1'b0, 5'd1, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1);
    directed("amt0", 1'b1, 5'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0);

    // backpressure: third request must stall with results held
    base = {16'd0, op_cnt};
    n = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 5'(i + 1), 32'h1111_0000 + i, 1'b0, acc);
      if (acc) n++;
    end
    chk("bp_accepted", n, 32'd2);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 5'd3, 32'h1111_0002, 1'b0, acc);
      chk("bp_in_ready", {31'd0, acc}, 32'd0);
      chk("bp_hold_data", if0.out_data, exp_q[0][31:0]);
    end
    for (int i = 0; i < 4; i++) idle(1'b1);
    chk("bp_drained", exp_q.size(), 32'd0);
    chk("bp_cnt", {16'd0, op_cnt} - base, 32'd2);

    // streaming with random operands
    chk_lat = 1'b1;
    for (int i = 0; i < 100; i++) begin
      d = 1'($urandom_range(1));
      a = 5'($urandom_range(31));
      x = $urandom;
      step(1'b1, d, a, x, 1'b1, acc);
      chk("stream_acc", {31'd0, acc}, 32'd1);
    end
    idle(1'b1);
    idle(1'b1);
    chk_lat = 1'b0;
    chk("stream_drained", exp_q.size(), 32'd0);
    chk("stream_cnt", {16'd0, op_cnt}, 32'(exp_cnt));

    // reset with two requests in flight
    step(1'b1, 1'b0, 5'd2, 32'h0000_0003, 1'b0, acc);
    step(1'b1, 1'b1, 5'd2, 32'hF000_0000, 1'b0, acc);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, if0.out_valid}, 32'd0);
    chk("mid_rst_cnt", {16'd0, op_cnt}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, if0.in_ready}, 32'd1);
    exp_q.delete();
    stamp_q.delete();
    exp_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) idle(1'b1);
    chk("post_rst_valid", {31'd0, if0.out_valid}, 32'd0);
    chk("post_rst_cnt", {16'd0, op_cnt}, 32'd0);

    // counter wrap on the 4-bit twin
    for (int i = 0; i < 17; i++) begin
      step(1'b1, 1'b0, 5'(i), 32'h0F0F_0F0F ^ i, 1'b1, acc);
    end
    idle(1'b1);
    idle(1'b1);
    chk("wrap_cnt16", {16'd0, op_cnt}, 32'd17);
    chk("wrap_cnt4", {28'd0, op_cnt_s}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
